// File: rtl/ball_pkg.sv
// Shared constants, FSM state encoding and coordinate types for the ball centroid path.
package ball_pkg;

  localparam int MAX_BALLS  = 7;
  localparam int BALL_ID_W  = 3;
  localparam int H_WIDTH    = 11;
  localparam int V_WIDTH    = 10;
  localparam int CNT_WIDTH  = 20;
  localparam int SUM_WIDTH  = 32;
  localparam int MIN_PIXELS = 16;
  localparam int DIV_CYC_W  = $clog2(SUM_WIDTH + 1);

  typedef logic [H_WIDTH-1:0] coord_x_t;
  typedef logic [V_WIDTH-1:0] coord_y_t;

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

  function automatic logic [BALL_ID_W-1:0] count_found(input logic [MAX_BALLS-1:0] found);
    logic [BALL_ID_W-1:0] total;
    total = '0;
    for (int b = 0; b < MAX_BALLS; b++)
      total = total + BALL_ID_W'(found[b]);
    return total;
  endfunction

endpackage

// File: rtl/centroid_divider.sv
// Unsigned restoring divider: start pulse loads operands, done pulses SUM_WIDTH cycles later.
module centroid_divider
  import ball_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start,
  input  logic [SUM_WIDTH-1:0] dividend,
  input  logic [CNT_WIDTH-1:0] divisor,
  output logic [SUM_WIDTH-1:0] quotient,
  output logic                 done
);

  logic [CNT_WIDTH-1:0] rem_q, rem_src, rem_next, div_q, div_src, diff;
  logic [SUM_WIDTH-1:0] quo_q, quo_src, quo_next;
  logic [CNT_WIDTH:0]   shifted;
  logic [DIV_CYC_W-1:0] steps_left;
  logic                 zero_q;

  // The start cycle already performs the first step so the last step lands SUM_WIDTH cycles later.
  always_comb begin
    rem_src = start ? '0 : rem_q;
    quo_src = start ? dividend : quo_q;
    div_src = start ? divisor : div_q;
    shifted = {rem_src, quo_src[SUM_WIDTH-1]};
    diff    = shifted[CNT_WIDTH-1:0] - div_src;
    if (shifted >= {1'b0, div_src}) begin
      rem_next = diff;
      quo_next = {quo_src[SUM_WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[CNT_WIDTH-1:0];
      quo_next = {quo_src[SUM_WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rem_q      <= '0;
      quo_q      <= '0;
      div_q      <= '0;
      zero_q     <= 1'b0;
      steps_left <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q      <= rem_next;
        quo_q      <= quo_next;
        div_q      <= divisor;
        zero_q     <= (divisor == '0);
        steps_left <= DIV_CYC_W'(SUM_WIDTH - 1);
      end else if (steps_left != '0) begin
        rem_q      <= rem_next;
        quo_q      <= quo_next;
        steps_left <= steps_left - DIV_CYC_W'(1);
        done       <= (steps_left == DIV_CYC_W'(1));
      end
    end
  end

  assign quotient = zero_q ? '0 : quo_q;

endmodule

// File: rtl/ball_centroid_accumulator.sv
// Per-frame ball centroid extractor: accumulates labelled pixels, divides at frame end.
// Define CENTROID_HOLD_EN to keep a not-found ball's previous coordinates instead of zeroing them.
module ball_centroid_accumulator
  import ball_pkg::*;
(
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              pixel_valid_in,
  input  logic [H_WIDTH-1:0]                hcount_in,
  input  logic [V_WIDTH-1:0]                vcount_in,
  input  logic [BALL_ID_W-1:0]              ball_id_in,
  input  logic                              frame_done_in,
  output logic [MAX_BALLS-1:0][H_WIDTH-1:0] real_balls_x,
  output logic [MAX_BALLS-1:0][V_WIDTH-1:0] real_balls_y,
  output logic [MAX_BALLS-1:0]              ball_found_out,
  output logic [BALL_ID_W-1:0]              num_found_out,
  output logic                              data_valid_out,
  output logic                              busy_out,
  output logic                              overrun_out
);

  logic [SUM_WIDTH-1:0] sum_x [MAX_BALLS], sum_y [MAX_BALLS];
  logic [SUM_WIDTH-1:0] sum_x_next [MAX_BALLS], sum_y_next [MAX_BALLS];
  logic [SUM_WIDTH-1:0] snap_sum_x [MAX_BALLS], snap_sum_y [MAX_BALLS];
  logic [CNT_WIDTH-1:0] cnt [MAX_BALLS], cnt_next [MAX_BALLS], snap_cnt [MAX_BALLS];
  coord_x_t             res_x [MAX_BALLS];
  coord_y_t             res_y [MAX_BALLS];

  state_t               state;
  logic [BALL_ID_W-1:0] ball_idx;
  logic                 axis;
  logic [DIV_CYC_W-1:0] div_cyc;
  logic [SUM_WIDTH-1:0] div_dividend, div_quotient;
  logic [CNT_WIDTH-1:0] div_divisor;
  logic                 div_start, div_done;
  logic [MAX_BALLS-1:0] found;

  always_comb begin
    for (int b = 0; b < MAX_BALLS; b++) begin
      sum_x_next[b] = sum_x[b];
      sum_y_next[b] = sum_y[b];
      cnt_next[b]   = cnt[b];
      if (pixel_valid_in && ball_id_in == BALL_ID_W'(b + 1)) begin
        sum_x_next[b] = sum_x[b] + SUM_WIDTH'(hcount_in);
        sum_y_next[b] = sum_y[b] + SUM_WIDTH'(vcount_in);
        if (cnt[b] != '1)
          cnt_next[b] = cnt[b] + CNT_WIDTH'(1);
      end
    end
  end

  // Live accumulators never stop; LOAD hands the finished frame to the snapshot and restarts.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int b = 0; b < MAX_BALLS; b++) begin
        sum_x[b] <= '0;  sum_y[b] <= '0;  cnt[b] <= '0;
        snap_sum_x[b] <= '0;  snap_sum_y[b] <= '0;  snap_cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < MAX_BALLS; b++) begin
        if (state == LOAD) begin
          snap_sum_x[b] <= sum_x_next[b];
          snap_sum_y[b] <= sum_y_next[b];
          snap_cnt[b]   <= cnt_next[b];
          sum_x[b] <= '0;  sum_y[b] <= '0;  cnt[b] <= '0;
        end else begin
          sum_x[b] <= sum_x_next[b];
          sum_y[b] <= sum_y_next[b];
          cnt[b]   <= cnt_next[b];
        end
      end
    end
  end

  always_comb begin
    div_dividend = '0;
    div_divisor  = '0;
    for (int b = 0; b < MAX_BALLS; b++) begin
      found[b] = snap_cnt[b] >= CNT_WIDTH'(MIN_PIXELS);
      if (ball_idx == BALL_ID_W'(b)) begin
        div_dividend = axis ? snap_sum_y[b] : snap_sum_x[b];
        div_divisor  = snap_cnt[b];
      end
    end
  end

  assign div_start = (state == DIV) && (div_cyc == '0);
  assign busy_out  = (state != IDLE);

  centroid_divider u_divider (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quotient (div_quotient),
    .done     (div_done)
  );

  // Every division takes a fixed SUM_WIDTH+1 slot so the frame latency never depends on the data.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IDLE;
      ball_idx       <= '0;
      axis           <= 1'b0;
      div_cyc        <= '0;
      data_valid_out <= 1'b0;
      overrun_out    <= 1'b0;
      ball_found_out <= '0;
      num_found_out  <= '0;
      real_balls_x   <= '0;
      real_balls_y   <= '0;
      for (int b = 0; b < MAX_BALLS; b++) begin
        res_x[b] <= '0;
        res_y[b] <= '0;
      end
    end else begin
      data_valid_out <= 1'b0;
      if (frame_done_in && state != IDLE)
        overrun_out <= 1'b1;
      unique case (state)
        IDLE: if (frame_done_in) state <= LOAD;
        LOAD: begin
          state    <= DIV;
          ball_idx <= '0;
          axis     <= 1'b0;
          div_cyc  <= '0;
        end
        DIV: begin
          for (int b = 0; b < MAX_BALLS; b++)
            if (div_done && ball_idx == BALL_ID_W'(b)) begin
              if (axis) res_y[b] <= coord_y_t'(div_quotient);
              else      res_x[b] <= coord_x_t'(div_quotient);
            end
          if (div_cyc == DIV_CYC_W'(SUM_WIDTH)) begin
            div_cyc <= '0;
            axis    <= ~axis;
            if (axis) begin
              if (ball_idx == BALL_ID_W'(MAX_BALLS - 1)) state <= DONE;
              else ball_idx <= ball_idx + BALL_ID_W'(1);
            end
          end else begin
            div_cyc <= div_cyc + DIV_CYC_W'(1);
          end
        end
        DONE: begin
          data_valid_out <= 1'b1;
          ball_found_out <= found;
          num_found_out  <= count_found(found);
          for (int b = 0; b < MAX_BALLS; b++) begin
`ifdef CENTROID_HOLD_EN
            if (found[b]) begin
              real_balls_x[b] <= res_x[b];
              real_balls_y[b] <= res_y[b];
            end
`else
            real_balls_x[b] <= found[b] ? res_x[b] : '0;
            real_balls_y[b] <= found[b] ? res_y[b] : '0;
`endif
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_centroid_accumulator.sv
// Directed bench for ball_centroid_accumulator with hand-computed centroids and latency.
module tb_ball_centroid_accumulator;
  import ball_pkg::*;

`ifdef CENTROID_HOLD_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif

  logic                              clk_in = 1'b0;
  logic                              rst_in = 1'b1;
  logic                              pixel_valid_in = 1'b0;
  logic [H_WIDTH-1:0]                hcount_in = '0;
  logic [V_WIDTH-1:0]                vcount_in = '0;
  logic [BALL_ID_W-1:0]              ball_id_in = '0;
  logic                              frame_done_in = 1'b0;
  logic [MAX_BALLS-1:0][H_WIDTH-1:0] real_balls_x;
  logic [MAX_BALLS-1:0][V_WIDTH-1:0] real_balls_y;
  logic [MAX_BALLS-1:0]              ball_found_out;
  logic [BALL_ID_W-1:0]              num_found_out;
  logic                              data_valid_out, busy_out, overrun_out;

  int   errorCount = 0;
  int   checkCount = 0;
  int   latency;
  int   validSeen;
  logic busyMid;

  always #5 clk_in = ~clk_in;

  ball_centroid_accumulator dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .pixel_valid_in (pixel_valid_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .ball_id_in     (ball_id_in),
    .frame_done_in  (frame_done_in),
    .real_balls_x   (real_balls_x),
    .real_balls_y   (real_balls_y),
    .ball_found_out (ball_found_out),
    .num_found_out  (num_found_out),
    .data_valid_out (data_valid_out),
    .busy_out       (busy_out),
    .overrun_out    (overrun_out)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One input cycle, driven on the falling edge.
  task automatic applyStimulus(input logic valid, input logic [H_WIDTH-1:0] x, input logic [V_WIDTH-1:0] y,
                               input logic [BALL_ID_W-1:0] id, input logic fd);
    @(negedge clk_in);
    pixel_valid_in = valid;
    hcount_in      = x;
    vcount_in      = y;
    ball_id_in     = id;
    frame_done_in  = fd;
  endtask

  task automatic sendPixels(input logic [BALL_ID_W-1:0] id, input logic [H_WIDTH-1:0] x,
                            input logic [V_WIDTH-1:0] y, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, x, y, id, 1'b0);
  endtask

  // Called right after a frame_done cycle; k counts cycles after the edge that sampled it.
  task automatic waitValid(input int fdAt, input int pxStart, input int pxCount, input logic [BALL_ID_W-1:0] pxId,
                           input logic [H_WIDTH-1:0] pxX, input logic [V_WIDTH-1:0] pxY,
                           output int cycles, output logic busySample);
    cycles     = 0;
    busySample = 1'b0;
    @(posedge clk_in); #1;
    for (int k = 0; k < 1000; k++) begin
      frame_done_in  = (k == fdAt);
      pixel_valid_in = (k >= pxStart) && (k < pxStart + pxCount);
      ball_id_in     = pxId;
      hcount_in      = pxX;
      vcount_in      = pxY;
      if (k == 50) busySample = busy_out;
      @(posedge clk_in); #1;
      if (data_valid_out) begin
        cycles = k + 1;
        break;
      end
    end
    frame_done_in  = 1'b0;
    pixel_valid_in = 1'b0;
  endtask

  initial begin
    $display("[TB] start, hold mode=%0d", HOLD);
    repeat (3) @(negedge clk_in);
    checkOutput("rst_x",       32'(|real_balls_x), 0);
    checkOutput("rst_y",       32'(|real_balls_y), 0);
    checkOutput("rst_found",   32'(ball_found_out), 0);
    checkOutput("rst_num",     32'(num_found_out), 0);
    checkOutput("rst_flags",   32'({data_valid_out, busy_out, overrun_out}), 0);
    rst_in = 1'b0;

    // Ball 1: 4x4 block at x=100..103, y=50..53.
    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 4; xx++)
        applyStimulus(1'b1, H_WIDTH'(100 + xx), V_WIDTH'(50 + yy), 3'd1, 1'b0);
    applyStimulus(1'b0, '0, '0, 3'd0, 1'b1);
    waitValid(-1, 0, 0, 3'd0, '0, '0, latency, busyMid);
    checkOutput("t1_latency", latency, 464);
    checkOutput("t1_busy_mid", 32'(busyMid), 1);
    checkOutput("t1_x1", 32'(real_balls_x[0]), 101);
    checkOutput("t1_y1", 32'(real_balls_y[0]), 51);
    checkOutput("t1_found", 32'(ball_found_out), 32'b0000001);
    checkOutput("t1_num", 32'(num_found_out), 1);
    checkOutput("t1_busy_after", 32'(busy_out), 0);
    @(posedge clk_in); #1;
    checkOutput("t1_valid_width", 32'(data_valid_out), 0);

    // Balls 1, 3, 7 with 25 pixels each.
    sendPixels(3'd1, 11'd640, 10'd360, 25);
    sendPixels(3'd3, 11'd10, 10'd700, 25);
    sendPixels(3'd7, 11'd1279, 10'd0, 25);
    applyStimulus(1'b0, '0, '0, 3'd0, 1'b1);
    waitValid(-1, 0, 0, 3'd0, '0, '0, latency, busyMid);
    checkOutput("t2_latency", latency, 464);
    checkOutput("t2_x1", 32'(real_balls_x[0]), 640);
    checkOutput("t2_y1", 32'(real_balls_y[0]), 360);
    checkOutput("t2_x3", 32'(real_balls_x[2]), 10);
    checkOutput("t2_y3", 32'(real_balls_y[2]), 700);
    checkOutput("t2_x7", 32'(real_balls_x[6]), 1279);
    checkOutput("t2_y7", 32'(real_balls_y[6]), 0);
    checkOutput("t2_x2", 32'(real_balls_x[1]), 0);
    checkOutput("t2_found", 32'(ball_found_out), 32'b1000101);
    checkOutput("t2_num", 32'(num_found_out), 3);

    // Exactly MIN_PIXELS is found, one fewer is not.
    sendPixels(3'd1, 11'd5, 10'd6, 16);
    sendPixels(3'd3, 11'd300, 10'd400, 15);
    applyStimulus(1'b0, '0, '0, 3'd0, 1'b1);
    waitValid(-1, 0, 0, 3'd0, '0, '0, latency, busyMid);
    checkOutput("t3_x1", 32'(real_balls_x[0]), 5);
    checkOutput("t3_y1", 32'(real_balls_y[0]), 6);
    checkOutput("t3_found", 32'(ball_found_out), 32'b0000001);
    checkOutput("t3_num", 32'(num_found_out), 1);
    checkOutput("t3_x3", 32'(real_balls_x[2]), HOLD ? 10 : 0);
    checkOutput("t3_y3", 32'(real_balls_y[2]), HOLD ? 700 : 0);
    checkOutput("t3_x7", 32'(real_balls_x[6]), HOLD ? 1279 : 0);

    // frame_done during DIV is ignored; pixels streamed during DIV land in the next frame.
    sendPixels(3'd4, 11'd111, 10'd222, 20);
    applyStimulus(1'b0, '0, '0, 3'd0, 1'b1);
    waitValid(100, 110, 20, 3'd5, 11'd333, 10'd444, latency, busyMid);
    checkOutput("t4_latency", latency, 464);
    checkOutput("t4_overrun", 32'(overrun_out), 1);
    checkOutput("t4_x4", 32'(real_balls_x[3]), 111);
    checkOutput("t4_y4", 32'(real_balls_y[3]), 222);
    checkOutput("t4_found", 32'(ball_found_out), 32'b0001000);
    checkOutput("t4_x1", 32'(real_balls_x[0]), HOLD ? 5 : 0);
    repeat (5) @(posedge clk_in);
    #1;
    checkOutput("t4_idle_after", 32'({busy_out, data_valid_out}), 0);
    applyStimulus(1'b0, '0, '0, 3'd0, 1'b1);
    waitValid(-1, 0, 0, 3'd0, '0, '0, latency, busyMid);
    checkOutput("t4b_latency", latency, 464);
    checkOutput("t4b_x5", 32'(real_balls_x[4]), 333);
    checkOutput("t4b_y5", 32'(real_balls_y[4]), 444);
    checkOutput("t4b_found", 32'(ball_found_out), 32'b0010000);

    // Pixel coincident with frame_done counts; background pixels do nothing.
    sendPixels(3'd0, 11'd1000, 10'd900, 5);
    sendPixels(3'd6, 11'd50, 10'd60, 15);
    applyStimulus(1'b1, 11'd66, 10'd76, 3'd6, 1'b1);
    waitValid(-1, 0, 0, 3'd0, '0, '0, latency, busyMid);
    checkOutput("t5_x6", 32'(real_balls_x[5]), 51);
    checkOutput("t5_y6", 32'(real_balls_y[5]), 61);
    checkOutput("t5_found", 32'(ball_found_out), 32'b0100000);
    checkOutput("t5_num", 32'(num_found_out), 1);
    checkOutput("t5_overrun_sticky", 32'(overrun_out), 1);

    // Reset at DIV cycle 200 clears everything asynchronously and suppresses the result.
    sendPixels(3'd1, 11'd20, 10'd30, 16);
    applyStimulus(1'b0, '0, '0, 3'd0, 1'b1);
    @(posedge clk_in); #1;
    frame_done_in = 1'b0;
    validSeen = 0;
    for (int k = 0; k < 200; k++) begin
      pixel_valid_in = (k >= 100) && (k < 116);
      ball_id_in     = 3'd2;
      hcount_in      = 11'd900;
      vcount_in      = 10'd900;
      @(posedge clk_in); #1;
      if (data_valid_out) validSeen++;
    end
    pixel_valid_in = 1'b0;
    #2 rst_in = 1'b1;
    #1;
    checkOutput("t6_x", 32'(|real_balls_x), 0);
    checkOutput("t6_y", 32'(|real_balls_y), 0);
    checkOutput("t6_found", 32'(ball_found_out), 0);
    checkOutput("t6_num", 32'(num_found_out), 0);
    checkOutput("t6_flags", 32'({busy_out, overrun_out}), 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk_in); #1;
      if (data_valid_out) validSeen++;
    end
    checkOutput("t6_no_valid", validSeen, 0);

    // Recovery frame starts from cleared accumulators.
    sendPixels(3'd2, 11'd7, 10'd8, 16);
    applyStimulus(1'b0, '0, '0, 3'd0, 1'b1);
    waitValid(-1, 0, 0, 3'd0, '0, '0, latency, busyMid);
    checkOutput("t7_latency", latency, 464);
    checkOutput("t7_x2", 32'(real_balls_x[1]), 7);
    checkOutput("t7_y2", 32'(real_balls_y[1]), 8);
    checkOutput("t7_found", 32'(ball_found_out), 32'b0000010);
    checkOutput("t7_overrun", 32'(overrun_out), 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
